// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
//
// Input-event controller for the board push-buttons and slide switches.
// Both buttons are synchronised and debounced. A debounced press (0->1) raises
// a per-button pending request that carries a snapshot of the synchronised
// switches. A fixed-priority arbiter (button 0 first) moves pending requests
// into one shared event FIFO. The consumer drains the FIFO through a
// valid/ready port, and irq mirrors evt_valid.
//
// Ports
//   HCLK          in   1   system clock, rising edge
//   HRESET        in   1   synchronous reset, active-high
//   Buttons       in   2   raw asynchronous push-buttons, 1 = pressed
//   Switches      in  16   raw asynchronous slide switches
//   evt_valid     out  1   head entry valid (registered)
//   evt_ready     in   1   consumer accepts head entry
//   evt_btn       out  1   button index of head entry (0 when empty)
//   evt_switches  out 16   switch snapshot of head entry (0 when empty)
//   drop_cnt      out  8   presses lost while a request was pending, saturating
//   irq           out  1   equals evt_valid
//
// Handshake: an entry transfers on a rising HCLK edge where evt_valid=1 and
// evt_ready=1. evt_valid/evt_btn/evt_switches are driven only by flops, so
// evt_ready never reaches an output combinationally. evt_ready while
// evt_valid=0 has no effect.
//
// FIFO organisation: the head entry lives in a dedicated output register
// (out_*_q). The remaining entries sit in a circular buffer (mem_*) with
// pointers wrapping modulo DEPTH. A newly written entry is moved into the
// output register on the following edge when the register is free, which
// gives the press-to-evt_valid latency of DEBOUNCE_CYCLES+3 edges. On a pop
// the next buffered entry is moved in on the same edge, so back-to-back
// entries stream out at one per cycle. Occupancy is the buffered count plus
// the output register; full means that sum equals DEPTH.
// -----------------------------------------------------------------------------
module button_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 32,  // 2..65535
  parameter int DEPTH           = 4    // power of two, 2..16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  Buttons,
  input  logic [15:0] Switches,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_btn,
  output logic [15:0] evt_switches,
  output logic [7:0]  drop_cnt,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]    bsync1_q, bsync_q;
  logic [15:0]   swsync1_q, swsync_q;
  logic [15:0]   cnt_q [2];
  logic [1:0]    stable_q;
  logic [1:0]    pending_q;
  logic [15:0]   snap_q [2];

  logic          mem_btn_q [DEPTH];
  logic [15:0]   mem_sw_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   mcnt_q;             // entries held in mem, excluding head

  logic          out_valid_q;
  logic          out_btn_q;
  logic [15:0]   out_sw_q;
  logic [7:0]    drop_q;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  logic [15:0]   cnt_d [2];
  logic [1:0]    stable_d;
  logic [1:0]    press;
  logic [1:0]    drop;
  logic [1:0]    pending_d;
  logic [15:0]   snap_d [2];
  logic          pop;
  logic [PW:0]   occupancy;
  logic          full;
  logic          push;
  logic          gsel;
  logic          load;
  logic [PW:0]   mcnt_d;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;
  logic [7:0]    drop_d;

  always_comb begin
    stable_d  = stable_q;
    press     = 2'b00;
    drop      = 2'b00;
    pending_d = pending_q;
    for (int n = 0; n < 2; n++) begin
      cnt_d[n]  = cnt_q[n];
      snap_d[n] = snap_q[n];
    end

    // Debounce: count consecutive cycles where the synchronised input differs
    // from the accepted level; any agreeing cycle restarts the count.
    for (int n = 0; n < 2; n++) begin
      if (bsync_q[n] == stable_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_LAST) begin
        stable_d[n] = ~stable_q[n];
        cnt_d[n]    = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + 16'd1;
      end
    end

    press = stable_d & ~stable_q;

    // FIFO side.
    pop       = out_valid_q & evt_ready;
    occupancy = mcnt_q + (PW + 1)'(out_valid_q);
    full      = (occupancy == FULL_LVL);

    // Fixed priority: button 0 wins. A pop on the same edge frees a slot.
    gsel = ~pending_q[0];
    push = (pending_q != 2'b00) && (!full || pop);

    // Head register refills from mem whenever it is empty or being popped.
    load = (!out_valid_q || pop) && (mcnt_q != '0);

    case ({push, load})
      2'b10:   mcnt_d = mcnt_q + (PW + 1)'(1);
      2'b01:   mcnt_d = mcnt_q - (PW + 1)'(1);
      default: mcnt_d = mcnt_q;
    endcase

    // Pending requests. A press that finds its request still pending (judged
    // on the pre-edge value, even if it is being pushed now) is dropped; the
    // queued request keeps its original snapshot.
    if (push) begin
      pending_d[gsel] = 1'b0;
    end
    for (int n = 0; n < 2; n++) begin
      if (press[n]) begin
        if (pending_q[n]) begin
          drop[n] = 1'b1;
        end else begin
          pending_d[n] = 1'b1;
          snap_d[n]    = swsync_q;
        end
      end
    end

    // Both buttons can drop on the same edge, so add up to two, saturating.
    drop_inc = {1'b0, drop[0]} + {1'b0, drop[1]};
    drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      bsync1_q    <= '0;
      bsync_q     <= '0;
      swsync1_q   <= '0;
      swsync_q    <= '0;
      for (int n = 0; n < 2; n++) begin
        cnt_q[n]  <= '0;
        snap_q[n] <= '0;
      end
      stable_q    <= '0;
      pending_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_btn_q   <= 1'b0;
      out_sw_q    <= '0;
      drop_q      <= '0;
    end else begin
      bsync1_q  <= Buttons;
      bsync_q   <= bsync1_q;
      swsync1_q <= Switches;
      swsync_q  <= swsync1_q;
      for (int n = 0; n < 2; n++) begin
        cnt_q[n]  <= cnt_d[n];
        snap_q[n] <= snap_d[n];
      end
      stable_q  <= stable_d;
      pending_q <= pending_d;
      mcnt_q    <= mcnt_d;
      drop_q    <= drop_d;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end

      if (load) begin
        out_valid_q <= 1'b1;
        out_btn_q   <= mem_btn_q[rd_ptr_q];
        out_sw_q    <= mem_sw_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + PW'(1);
      end else if (pop) begin
        // Emptied: head fields read 0.
        out_valid_q <= 1'b0;
        out_btn_q   <= 1'b0;
        out_sw_q    <= '0;
      end
    end
  end

  // Entry storage needs no reset: it is only read behind mcnt_q != 0.
  always_ff @(posedge HCLK) begin
    if (!HRESET && push) begin
      mem_btn_q[wr_ptr_q] <= gsel;
      mem_sw_q[wr_ptr_q]  <= snap_q[gsel];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from flops
  // ---------------------------------------------------------------------------
  assign evt_valid    = out_valid_q;
  assign evt_btn      = out_btn_q;
  assign evt_switches = out_sw_q;
  assign drop_cnt     = drop_q;
  assign irq          = out_valid_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_event_ctrl
//
// Bench for button_event_ctrl (DEBOUNCE_CYCLES=32, DEPTH=4). A reference model
// runs alongside every clock edge and predicts the outputs from the
// behavioural rules: a two-sample delay line for synchronisation, a
// "how long has the input disagreed" rule for debounce, pending flags with
// snapshots, and a time-stamped event queue for the FIFO. Directed sequences
// and a vector table add explicit checks on latency, ordering and boundaries.
// -----------------------------------------------------------------------------
module tb_button_event_ctrl;

  localparam int DEB   = 32;
  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        HCLK      = 1'b0;
  logic        HRESET    = 1'b1;
  logic [1:0]  Buttons   = 2'b00;
  logic [15:0] Switches  = 16'h0000;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic        evt_btn;
  logic [15:0] evt_switches;
  logic [7:0]  drop_cnt;
  logic        irq;

  always #5 HCLK = ~HCLK;

  button_event_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DEPTH          (DEPTH)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .Buttons     (Buttons),
    .Switches    (Switches),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_btn     (evt_btn),
    .evt_switches(evt_switches),
    .drop_cnt    (drop_cnt),
    .irq         (irq)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int total       = 0;
  int bad         = 0;
  int cyc         = 0;   // index of the most recent rising edge
  int valid_hi    = 0;   // cycles with evt_valid=1 since last clear
  int first_valid = -1;  // first edge after which evt_valid=1 since last clear

  typedef struct {
    logic        btn;
    logic [15:0] sw;
  } ev_t;
  ev_t got_q[$];         // entries the consumer actually accepted

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        btn;
    logic [15:0] sw;
    int          t;      // edge at which the entry was queued
  } ent_t;

  ent_t        m_q[$];
  logic [1:0]  m_s1 = 0, m_s2 = 0;     // button samples delayed by 1 and 2 edges
  logic [15:0] m_w1 = 0, m_w2 = 0;     // switch samples delayed by 1 and 2 edges
  logic [1:0]  m_stable = 0;
  int          m_agree[2] = '{0, 0};   // last edge the input agreed with stable
  logic [1:0]  m_pend = 0;
  logic [15:0] m_snap[2] = '{16'h0, 16'h0};
  int          m_drop = 0;

  // An entry queued at edge t is first visible after edge t+1.
  function automatic bit m_visible_after(input int k);
    if (m_q.size() == 0) return 1'b0;
    return (m_q[0].t <= k - 1);
  endfunction

  task automatic model_edge(input int k);
    logic [1:0]  bs;
    logic [15:0] ws;
    logic [1:0]  pb;
    bit          pop_now;
    bit          full_now;
    int          g;
    if (HRESET) begin
      m_q.delete();
      m_s1 = 0; m_s2 = 0; m_w1 = 0; m_w2 = 0;
      m_stable = 0; m_pend = 0; m_drop = 0;
      m_snap[0] = 0; m_snap[1] = 0;
      m_agree[0] = k; m_agree[1] = k;
      return;
    end
    bs = m_s2;
    ws = m_w2;
    pb = m_pend;
    pop_now  = m_visible_after(k - 1) && evt_ready;
    full_now = (m_q.size() == DEPTH);
    if (pop_now) void'(m_q.pop_front());
    if (pb != 2'b00 && (!full_now || pop_now)) begin
      g = pb[0] ? 0 : 1;
      m_q.push_back('{btn: g[0], sw: m_snap[g], t: k});
      m_pend[g] = 1'b0;
    end
    for (int n = 0; n < 2; n++) begin
      if (bs[n] == m_stable[n]) begin
        m_agree[n] = k;
      end else if (k - m_agree[n] >= DEB) begin
        m_stable[n] = ~m_stable[n];
        m_agree[n]  = k;
        if (m_stable[n]) begin
          if (pb[n]) begin
            if (m_drop < 255) m_drop++;
          end else begin
            m_pend[n] = 1'b1;
            m_snap[n] = ws;
          end
        end
      end
    end
    m_s2 = m_s1; m_s1 = Buttons;
    m_w2 = m_w1; m_w1 = Switches;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock edge, model update, compare after the edge
  // ---------------------------------------------------------------------------
  task automatic step();
    logic [26:0] act;
    logic [26:0] exp;
    bit          v;
    if (evt_valid === 1'b1 && evt_ready === 1'b1)
      got_q.push_back('{btn: evt_btn, sw: evt_switches});
    @(posedge HCLK);
    cyc++;
    model_edge(cyc);
    #1;
    v   = m_visible_after(cyc);
    exp = {v, v ? m_q[0].btn : 1'b0, v ? m_q[0].sw : 16'h0, 8'(m_drop), v};
    act = {evt_valid, evt_btn, evt_switches, drop_cnt, irq};
    chk("outputs_vs_model", 32'(act), 32'(exp));
    if (evt_valid === 1'b1) begin
      valid_hi++;
      if (first_valid < 0) first_valid = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
  endtask

  task automatic clear_obs();
    got_q.delete();
    valid_hi    = 0;
    first_valid = -1;
  endtask

  task automatic press(input logic [1:0] mask, input int hi, input int lo);
    Buttons = mask;
    run(hi);
    Buttons = 2'b00;
    run(lo);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: single press after reset, drained with evt_ready=1
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] sw;
    logic [1:0]  btn;
    int          hold;
    int          exp_events;
    logic        exp_btn;
    logic [15:0] exp_sw;
  } vec_t;

  vec_t vecs[6];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    int r_edge;
    int left[2];

    vecs[0] = '{sw: 16'h0003, btn: 2'b01, hold: 50, exp_events: 1, exp_btn: 1'b0, exp_sw: 16'h0003};
    vecs[1] = '{sw: 16'hA5A5, btn: 2'b10, hold: 50, exp_events: 1, exp_btn: 1'b1, exp_sw: 16'hA5A5};
    vecs[2] = '{sw: 16'h1234, btn: 2'b01, hold: 20, exp_events: 0, exp_btn: 1'b0, exp_sw: 16'h0000};
    vecs[3] = '{sw: 16'hFFFF, btn: 2'b10, hold: 32, exp_events: 1, exp_btn: 1'b1, exp_sw: 16'hFFFF};
    vecs[4] = '{sw: 16'h7777, btn: 2'b01, hold: 31, exp_events: 0, exp_btn: 1'b0, exp_sw: 16'h0000};
    vecs[5] = '{sw: 16'h0C0C, btn: 2'b11, hold: 50, exp_events: 2, exp_btn: 1'b0, exp_sw: 16'h0C0C};

    // Reset state
    do_reset();
    chk("reset_outputs", {5'd0, evt_valid, evt_btn, evt_switches, drop_cnt, irq}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      do_reset();
      Switches  = vecs[i].sw;
      Buttons   = 2'b00;
      evt_ready = 1'b1;
      run(4);
      clear_obs();
      press(vecs[i].btn, vecs[i].hold, 80);
      chk("vec_event_count", 32'(got_q.size()), 32'(vecs[i].exp_events));
      if (got_q.size() > 0) begin
        chk("vec_first_btn", 32'(got_q[0].btn), 32'(vecs[i].exp_btn));
        chk("vec_first_sw", 32'(got_q[0].sw), 32'(vecs[i].exp_sw));
      end
      chk("vec_drop", 32'(drop_cnt), 32'd0);
    end

    // Press latency: one press, evt_ready=1, valid for exactly one cycle
    do_reset();
    Switches  = 16'h0003;
    evt_ready = 1'b1;
    run(5);
    clear_obs();
    e0 = cyc + 1;
    press(2'b01, 50, 100);
    chk("lat_first_valid_edge", 32'(first_valid - e0), 32'(DEB + 3));
    chk("lat_valid_cycles", 32'(valid_hi), 32'd1);
    chk("lat_events", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) begin
      chk("lat_btn", 32'(got_q[0].btn), 32'd0);
      chk("lat_sw", 32'(got_q[0].sw), 32'h0003);
    end
    chk("lat_drop", 32'(drop_cnt), 32'd0);

    // Short press and bouncing input: no event
    do_reset();
    clear_obs();
    press(2'b10, 20, 40);
    for (int i = 0; i < 200; i++) begin
      Buttons = {((i / 5) % 2 == 0), 1'b0};
      step();
    end
    Buttons = 2'b00;
    run(60);
    chk("bounce_valid_cycles", 32'(valid_hi), 32'd0);
    chk("bounce_events", 32'(got_q.size()), 32'd0);

    // Simultaneous presses: button 0 before button 1
    do_reset();
    Switches  = 16'h000C;
    evt_ready = 1'b0;
    run(4);
    clear_obs();
    press(2'b11, 50, 60);
    chk("both_head_valid", 32'(evt_valid), 32'd1);
    chk("both_head_btn", 32'(evt_btn), 32'd0);
    evt_ready = 1'b1;
    run(10);
    chk("both_events", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("both_btn0", 32'(got_q[0].btn), 32'd0);
      chk("both_btn1", 32'(got_q[1].btn), 32'd1);
      chk("both_sw0", 32'(got_q[0].sw), 32'h000C);
      chk("both_sw1", 32'(got_q[1].sw), 32'h000C);
    end
    chk("both_empty", 32'(evt_valid), 32'd0);

    // Overflow: six presses, FIFO 4 + pending 1 + one drop
    do_reset();
    evt_ready = 1'b0;
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      Switches = 16'(i);
      press(2'b01, 50, 50);
    end
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    run(20);
    chk("ovf_events", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      chk("ovf_order_sw", 32'(got_q[i].sw), 32'(i));
      chk("ovf_btn", 32'(got_q[i].btn), 32'd0);
    end
    chk("ovf_empty", 32'(evt_valid), 32'd0);

    // Full FIFO plus pending button 1: one-cycle pop pushes the pending entry
    do_reset();
    evt_ready = 1'b0;
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      Switches = 16'(i);
      press(2'b01, 50, 50);
    end
    Switches = 16'hBEEF;
    press(2'b10, 50, 50);
    chk("full_head_sw", 32'(evt_switches), 32'h0000);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    run(2);
    chk("full_pulse_pops", 32'(got_q.size()), 32'd1);
    chk("full_next_head_sw", 32'(evt_switches), 32'h0001);
    got_q.delete();
    evt_ready = 1'b1;
    run(10);
    chk("full_remaining", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("full_last_btn", 32'(got_q[3].btn), 32'd1);
      chk("full_last_sw", 32'(got_q[3].sw), 32'hBEEF);
      chk("full_third_sw", 32'(got_q[2].sw), 32'h0003);
    end
    chk("full_empty", 32'(evt_valid), 32'd0);

    // Reset in the middle of a press with two queued entries
    do_reset();
    evt_ready = 1'b0;
    Switches  = 16'h0007;
    press(2'b01, 50, 50);
    Switches  = 16'h0008;
    press(2'b01, 50, 50);
    Switches  = 16'h0009;
    Buttons   = 2'b01;
    run(19);
    HRESET = 1'b1;
    step();
    r_edge = cyc;
    HRESET = 1'b0;
    chk("midrst_outputs", {5'd0, evt_valid, evt_btn, evt_switches, drop_cnt, irq}, 32'd0);
    clear_obs();
    run(80);
    Buttons = 2'b00;
    run(20);
    chk("midrst_first_valid", 32'(first_valid - r_edge), 32'(DEB + 4));
    chk("midrst_head_btn", 32'(evt_btn), 32'd0);
    chk("midrst_head_sw", 32'(evt_switches), 32'h0009);
    evt_ready = 1'b1;
    run(5);
    chk("midrst_events", 32'(got_q.size()), 32'd1);

    // Randomised traffic against the model
    do_reset();
    left[0] = 0;
    left[1] = 0;
    for (int i = 0; i < 6000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (left[n] == 0) begin
          Buttons[n] = ~Buttons[n];
          left[n]    = $urandom_range(1, 70);
        end else begin
          left[n]--;
        end
      end
      if ($urandom_range(0, 15) == 0) Switches = 16'($urandom);
      evt_ready = ($urandom_range(0, 3) == 0);
      HRESET    = ($urandom_range(0, 1999) == 0);
      step();
    end
    HRESET    = 1'b0;
    Buttons   = 2'b00;
    evt_ready = 1'b1;
    run(120);
    chk("final_drained", 32'(evt_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: simulation did not complete, edge %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
